// File: rtl/wave_scroller.sv
// Frame-rate animation controller: advances scroll offset and phase once per accepted
// frame tick, indexes the external sine LUT and registers the resulting wave height.
module wave_scroller #(
  parameter logic [9:0] SCREEN_W   = 10'd640,
  parameter logic [9:0] BASE_Y     = 10'd180,
  parameter logic [7:0] PHASE_STEP = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [3:0] lut_pos,
  input  logic [7:0] lut_data,
  output logic [9:0] x_offset,
  output logic [9:0] wave_y,
  output logic       wave_valid,
  output logic       overrun
);

  localparam int unsigned XW = 10;
  localparam int unsigned SW = XW + 1;
  localparam int unsigned PW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [3:0]      pos_q, pos_d;
  logic [XW-1:0]   wave_y_q, wave_y_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic [SW-1:0]   sum_c;
  logic [XW-1:0]   x_next_c;
  logic [PW-1:0]   phase_next_c;

  // Scroll step is speed+1; the sum never exceeds 2*SCREEN_W so one subtraction wraps it.
  always_comb begin
    sum_c        = SW'(x_q) + SW'(speed) + SW'(1);
    x_next_c     = (sum_c >= SW'(SCREEN_W)) ? XW'(sum_c - SW'(SCREEN_W)) : XW'(sum_c);
    phase_next_c = phase_q + PHASE_STEP;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    wave_y_d  = wave_y_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (frame_tick && run) begin
          x_d     = x_next_c;
          phase_d = phase_next_c;
          pos_d   = phase_next_c[7:4];
          state_d = FETCH;
        end
      end
      FETCH: begin
        wave_y_d = BASE_Y + {2'b00, lut_data};
        valid_d  = 1'b1;
        state_d  = DONE;
        if (frame_tick && run) overrun_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if (frame_tick && run) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      phase_q   <= '0;
      pos_q     <= '0;
      wave_y_q  <= BASE_Y;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      wave_y_q  <= wave_y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign lut_pos    = pos_q;
  assign x_offset   = x_q;
  assign wave_y     = wave_y_q;
  assign wave_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wave_scroller.sv
// Directed bench for wave_scroller with a local 16-entry sine table standing in for sine_lut.
module tb_wave_scroller;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       run;
  logic [2:0] speed;
  logic [3:0] lut_pos;
  logic [7:0] lut_data;
  logic [9:0] x_offset;
  logic [9:0] wave_y;
  logic       wave_valid;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int v0;

  wave_scroller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .run        (run),
    .speed      (speed),
    .lut_pos    (lut_pos),
    .lut_data   (lut_data),
    .x_offset   (x_offset),
    .wave_y     (wave_y),
    .wave_valid (wave_valid),
    .overrun    (overrun)
  );

  function automatic logic [7:0] sine_ref(input logic [3:0] i);
    case (i)
      4'd0:  sine_ref = 8'd128;
      4'd1:  sine_ref = 8'd177;
      4'd2:  sine_ref = 8'd218;
      4'd3:  sine_ref = 8'd245;
      4'd4:  sine_ref = 8'd255;
      4'd5:  sine_ref = 8'd245;
      4'd6:  sine_ref = 8'd218;
      4'd7:  sine_ref = 8'd177;
      4'd8:  sine_ref = 8'd128;
      4'd9:  sine_ref = 8'd79;
      4'd10: sine_ref = 8'd38;
      4'd11: sine_ref = 8'd11;
      4'd12: sine_ref = 8'd1;
      4'd13: sine_ref = 8'd11;
      4'd14: sine_ref = 8'd38;
      default: sine_ref = 8'd79;
    endcase
  endfunction

  assign lut_data = sine_ref(lut_pos);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wave_valid === 1'b1) vcnt++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One accepted frame, ending back in IDLE three edges later.
  task automatic do_frame(input logic [2:0] spd);
    frame_tick = 1'b1;
    run        = 1'b1;
    speed      = spd;
    step();
    frame_tick = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; speed = 3'd0;
    step();
    step();
    check("rst_x_offset", x_offset, 0);
    check("rst_lut_pos", lut_pos, 0);
    check("rst_wave_y", wave_y, 180);
    check("rst_wave_valid", wave_valid, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    step();

    // single frame, speed 0
    v0 = vcnt;
    frame_tick = 1'b1; run = 1'b1; speed = 3'd0;
    step();
    frame_tick = 1'b0;
    check("single_x_after_e0", x_offset, 1);
    check("single_pos_after_e0", lut_pos, 1);
    check("single_valid_after_e0", wave_valid, 0);
    step();
    check("single_valid_after_e1", wave_valid, 1);
    check("single_wave_y", wave_y, 180 + sine_ref(4'd1));
    step();
    check("single_valid_after_e2", wave_valid, 0);
    step();
    check("single_pulse_count", vcnt - v0, 1);

    // scroll wrap
    do_reset();
    v0 = vcnt;
    do_frame(3'd0);
    for (int i = 0; i < 79; i++) do_frame(3'd7);
    check("wrap_x_633", x_offset, 633);
    do_frame(3'd7);
    check("wrap_x_1", x_offset, 1);
    check("wrap_pos", lut_pos, 1);
    check("wrap_wave_y", wave_y, 357);
    check("wrap_pulse_count", vcnt - v0, 81);

    // phase wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_frame(3'd0);
    check("phase_pos", lut_pos, 0);
    check("phase_wave_y", wave_y, 308);
    check("phase_x", x_offset, 16);

    // run low: ticks ignored
    v0 = vcnt;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    check("norun_x", x_offset, 16);
    check("norun_pos", lut_pos, 0);
    check("norun_wave_y", wave_y, 308);
    check("norun_pulses", vcnt - v0, 0);
    check("norun_overrun", overrun, 0);

    // back-to-back ticks: second lands in FETCH
    run = 1'b1; speed = 3'd0; frame_tick = 1'b1;
    step();
    check("ovr_x_first", x_offset, 17);
    check("ovr_overrun_before", overrun, 0);
    step();
    frame_tick = 1'b0;
    check("ovr_overrun_set", overrun, 1);
    check("ovr_x_held", x_offset, 17);
    step();
    step();
    check("ovr_x_final", x_offset, 17);
    check("ovr_pos_final", lut_pos, 1);
    check("ovr_wave_y", wave_y, 357);
    check("ovr_sticky", overrun, 1);

    // reset asserted while in FETCH
    v0 = vcnt;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("fetch_x_pre_reset", x_offset, 18);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", x_offset, 0);
    check("mid_rst_pos", lut_pos, 0);
    check("mid_rst_wave_y", wave_y, 180);
    check("mid_rst_valid", wave_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst_pulses", vcnt - v0, 0);
    check("post_rst_wave_y", wave_y, 180);
    check("post_rst_x", x_offset, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_scroller.md
# wave_scroller

Frame-rate animation controller for the sine-wave obstacle path. Once per video frame it advances a horizontal scroll offset and a phase accumulator, and drives the 4-bit `pos` index of the `sine_lut` stage. It captures the LUT's 8-bit `sin_output` into a registered vertical position, `wave_y`. It sits between the VGA timing generator, which supplies `frame_tick`, and the sine/obstacle drawing logic, which consumes `x_offset` and `wave_y`.

## Interface
Parameters:
- `SCREEN_W`, default 10'd640: horizontal wrap modulus for `x_offset`.
- `BASE_Y`, default 10'd180: vertical base added to the LUT sample.
- `PHASE_STEP`, default 8'd16: phase increment per accepted frame. The default advances `pos` by 1 per frame.

Ports:
- `clk`  in  1: system/pixel clock. This is the only clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `frame_tick`  in  1: one-cycle pulse at the start of vertical blanking.
- `run`  in  1: animation enable. When 0, the block holds all state.
- `speed`  in  3: scroll step select. The step is `speed + 1`, range 1..8 pixels per frame.
- `lut_pos`  out  4: registered index driven into `sine_lut.pos`.
- `lut_data`  in  8: combinational `sine_lut.sin_output` for the current `lut_pos`.
- `x_offset`  out  10: scroll offset, always in 0..SCREEN_W-1.
- `wave_y`  out  10: registered vertical wave position.
- `wave_valid`  out  1: one-cycle pulse when `wave_y` has just been updated.
- `overrun`  out  1: sticky flag. Set when a `frame_tick` arrives while the block is busy.

## Operation
- The FSM has three states: IDLE, FETCH, DONE.
  - IDLE: on `frame_tick & run`, perform the frame update (listed below) and go to FETCH.
    - If `frame_tick` is seen with `run` = 0, ignore it and stay in IDLE.
  - FETCH: `wave_y <= BASE_Y + {2'b00, lut_data}` (10-bit add). Set `wave_valid <= 1`. Go to DONE.
  - DONE: `wave_valid <= 0`. Go to IDLE.
- Frame update, all registered on the same edge:
  - `sum = x_offset + speed + 1`, computed in 11 bits.
  - `x_offset <= (sum >= SCREEN_W) ? sum - SCREEN_W : sum`.
  - `phase <= phase + PHASE_STEP`, 8-bit, wrapping mod 256.
  - `lut_pos <= (phase + PHASE_STEP)[7:4]`, i.e. taken from the next phase value.
- `speed` is sampled only on the accepting edge.
- `frame_tick` in FETCH or DONE:
  - Dropped: no update to `x_offset`, `phase` or `lut_pos`.
  - If `run` = 1, `overrun <= 1`.
- `overrun` clears only on reset.
- `run` deasserting in FETCH or DONE does not abort the sequence: the FSM completes and returns to IDLE.
- `BASE_Y + 255` must be ≤ 1023. Overflow is out of scope; parameters are chosen so that it does not occur.

## Timing
- Reset values:
  - state IDLE
  - `x_offset` 0
  - phase 0
  - `lut_pos` 0
  - `wave_y` `BASE_Y`
  - `wave_valid` 0
  - `overrun` 0
- Edge E0 samples `frame_tick` = 1 in IDLE with `run` = 1:
  - `x_offset` and `lut_pos` are new after E0.
  - `lut_data` settles combinationally during the cycle after E0.
- Edge E1:
  - `wave_y` updates.
  - `wave_valid` is high for exactly the cycle between E1 and E2.
- Latency from tick to `wave_valid` is 2 edges.
- Minimum spacing between accepted ticks is 3 cycles. Real frame spacing of roughly 420k cycles is far above this.
- `x_offset` is stable between frame updates; downstream may sample it combinationally during active video.
- Reset asserted mid-sequence returns every output to its reset value immediately (asynchronous). No `wave_valid` pulse follows.

## Test plan
- Reset check: hold `rst_n` = 0 → `x_offset` 0, `lut_pos` 0, `wave_y` 180, `wave_valid` 0, `overrun` 0.
- Single frame, `speed` = 0, `run` = 1, tick at E0:
  - After E0: `x_offset` = 1 and `lut_pos` = 1.
  - `wave_y` = 180 + `sine_lut`(1), compared against a reference `sine_lut` instance.
  - `wave_valid` is high for exactly 1 cycle, 2 edges after the tick.
- Wrap, starting from reset:
  - 1 tick at `speed` 0, then 79 ticks at `speed` 7 → `x_offset` 633.
  - 1 more tick at `speed` 7 → `x_offset` 1.
  - `lut_pos` after these 81 ticks = 81 mod 16 = 1.
- Phase wrap: 16 ticks from reset → `lut_pos` returns to 0 and `wave_y` = 180 + `sine_lut`(0).
- `run` = 0: 5 ticks → no change to `x_offset`, `lut_pos` or `wave_y`; no `wave_valid`; `overrun` stays 0.
- Overrun and reset:
  - Tick, then a second tick 1 cycle later (FETCH) → only one update (`x_offset` +1) and `overrun` = 1.
  - Then assert `rst_n` = 0 in FETCH → all outputs at reset values; no `wave_valid`.
